// File: rtl/y86_alu_if.sv
// Issue/result bundle for the y86_alu execute-stage ALU.
// zf/sf exist only when ALU_FLAGS_EN is defined.
interface y86_alu_if;
    logic        en;
    logic [1:0]  control;
    logic [63:0] A;
    logic [63:0] B;
    logic [63:0] C;
    logic        overflow;
    logic        out_valid;
`ifdef ALU_FLAGS_EN
    logic        zf;
    logic        sf;

    modport master (output en, control, A, B, input C, overflow, out_valid, zf, sf);
    modport slave  (input en, control, A, B, output C, overflow, out_valid, zf, sf);
`else
    modport master (output en, control, A, B, input C, overflow, out_valid);
    modport slave  (input en, control, A, B, output C, overflow, out_valid);
`endif
endinterface

// File: rtl/y86_alu.sv
// 64-bit Y86-64 ALU: ADD/SUB/AND/XOR with signed overflow, one registered stage.
// Define ALU_FLAGS_EN to add registered zf/sf outputs.
module y86_alu (
    input  logic     clk,
    input  logic     rst,
    y86_alu_if.slave alu
);
    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_XOR = 2'b11
    } op_e;

    logic [63:0] c_d, c_q;
    logic        ovf_d, ovf_q;
    logic        vld_q;

    always_comb begin
        c_d   = '0;
        ovf_d = 1'b0;
        case (op_e'(alu.control))
            OP_ADD: begin
                c_d   = alu.A + alu.B;
                ovf_d = (alu.A[63] == alu.B[63]) && (c_d[63] != alu.A[63]);
            end
            OP_SUB: begin
                c_d   = alu.A - alu.B;
                ovf_d = (alu.A[63] != alu.B[63]) && (c_d[63] != alu.A[63]);
            end
            OP_AND:  c_d = alu.A & alu.B;
            default: c_d = alu.A ^ alu.B;
        endcase
    end

    // Result holds while en is low; only the valid strobe tracks every edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_q   <= '0;
            ovf_q <= 1'b0;
            vld_q <= 1'b0;
        end else begin
            vld_q <= alu.en;
            if (alu.en) begin
                c_q   <= c_d;
                ovf_q <= ovf_d;
            end
        end
    end

    assign alu.C         = c_q;
    assign alu.overflow  = ovf_q;
    assign alu.out_valid = vld_q;

`ifdef ALU_FLAGS_EN
    logic zf_q, sf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zf_q <= 1'b0;
            sf_q <= 1'b0;
        end else if (alu.en) begin
            zf_q <= (c_d == 64'd0);
            sf_q <= c_d[63];
        end
    end

    assign alu.zf = zf_q;
    assign alu.sf = sf_q;
`endif
endmodule

// File: tb/tb_y86_alu.sv
// Scoreboard bench for y86_alu: randomized and directed ops against a signed-arithmetic model.
module tb_y86_alu;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    y86_alu_if bus ();
    y86_alu dut (.clk(clk), .rst(rst), .alu(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [63:0] c;
        logic        ovf;
        logic        zf;
        logic        sf;
        int          due;
    } exp_t;

    exp_t q[$];
    exp_t last;

    localparam logic signed [64:0] SMAX = 65'sh0_7FFF_FFFF_FFFF_FFFF;
    localparam logic signed [64:0] SMIN = 65'sh1_8000_0000_0000_0000;

    // Exact signed math in 65 bits; overflow means the true result leaves the 64-bit range.
    function automatic exp_t model(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
        exp_t e;
        logic signed [64:0] sa, sb, w;
        sa = $signed({a[63], a});
        sb = $signed({b[63], b});
        w  = '0;
        e.ovf = 1'b0;
        case (op)
            2'd0: begin w = sa + sb; e.ovf = (w > SMAX) || (w < SMIN); end
            2'd1: begin w = sa - sb; e.ovf = (w > SMAX) || (w < SMIN); end
            2'd2: w = {1'b0, a & b};
            default: w = {1'b0, a ^ b};
        endcase
        e.c   = w[63:0];
        e.zf  = (e.c == 64'd0);
        e.sf  = e.c[63];
        e.due = 0;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic chk_state(input string tag, input exp_t e);
        chk({tag, " C"}, bus.C, e.c);
        chk({tag, " overflow"}, {63'd0, bus.overflow}, {63'd0, e.ovf});
`ifdef ALU_FLAGS_EN
        chk({tag, " zf"}, {63'd0, bus.zf}, {63'd0, e.zf});
        chk({tag, " sf"}, {63'd0, bus.sf}, {63'd0, e.sf});
`endif
    endtask

    function automatic exp_t zero_exp();
        exp_t z;
        z.c = '0; z.ovf = 1'b0; z.zf = 1'b0; z.sf = 1'b0; z.due = 0;
        return z;
    endfunction

    // Monitor: each negedge, out_valid must match whether a result is due this cycle.
    always @(negedge clk) begin
        if (rst) begin
            chk("reset out_valid", {63'd0, bus.out_valid}, 64'd0);
            chk_state("reset", zero_exp());
        end else begin
            automatic logic due = (q.size() > 0) && (q[0].due == cyc);
            chk("out_valid", {63'd0, bus.out_valid}, {63'd0, due});
            if (due) begin
                last = q.pop_front();
                chk_state("result", last);
            end else begin
                chk_state("hold", last);
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
        exp_t e;
        @(posedge clk);
        #1;
        bus.en = 1'b1;
        bus.control = op;
        bus.A = a;
        bus.B = b;
        e = model(op, a, b);
        e.due = cyc + 1;
        q.push_back(e);
    endtask

    // Idle cycle with garbage operands: must not disturb held outputs.
    task automatic idle();
        @(posedge clk);
        #1;
        bus.en = 1'b0;
        bus.control = 2'($urandom_range(3));
        bus.A = {$urandom, $urandom};
        bus.B = {$urandom, $urandom};
    endtask

    function automatic logic [63:0] pick();
        case ($urandom_range(7))
            0: return 64'h7FFF_FFFF_FFFF_FFFF;
            1: return 64'h8000_0000_0000_0000;
            2: return 64'hFFFF_FFFF_FFFF_FFFF;
            3: return 64'd8;
            4: return 64'd0;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        rst = 1'b1;
        bus.en = 1'b0;
        bus.control = 2'd0;
        bus.A = '0;
        bus.B = '0;
        last = zero_exp();
        #1;
        chk("por out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk_state("por", zero_exp());
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Directed cases
        issue(2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
        issue(2'd1, 64'h100, 64'd8);
        issue(2'd1, 64'h8000_0000_0000_0000, 64'd1);
        issue(2'd2, 64'hF0F0, 64'h0FF0);
        issue(2'd3, 64'h1234, 64'h1234);
        idle();
        idle();
        // Three back-to-back then hold
        issue(2'd0, 64'd10, 64'd20);
        issue(2'd1, 64'd5, 64'd7);
        issue(2'd3, 64'hAAAA, 64'h5555);
        repeat (3) idle();

        // Randomized traffic with gaps
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(3) == 0) idle();
            else issue(2'($urandom_range(3)), pick(), pick());
        end
        repeat (2) idle();

        // Async reset in the middle of a pending operation
        issue(2'd0, 64'd5, 64'd6);
        issue(2'd0, 64'd100, 64'd200);
        #2;
        rst = 1'b1;
        bus.en = 1'b0;
        #1;
        chk("midreset out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk_state("midreset", zero_exp());
        q.delete();
        last = zero_exp();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        idle();
        issue(2'd1, 64'h100, 64'd8);
        issue(2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
        repeat (3) idle();

        chk("drained", 64'(q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
